// File: rtl/lock_pkg.sv
// Shared constants and encodings for the code-entry / lock datapath.
//   DIGIT_W     width of one entered digit
//   MAX_DIGIT   largest legal decimal digit; anything above is flagged
//   CODE_LEN    default number of digits per complete code
//   CNT_W       width of the per-code digit counter
//   out_state_t output register state (EMPTY: nothing held, FULL: digit held)
package lock_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned MAX_DIGIT = 9;
    localparam int unsigned CODE_LEN  = 6;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/code_entry_if.sv
// Digit hand-off bus between code_entry and the downstream lock FSM.
//   digit/digit_err  captured digit and its >9 flag, qualified by digit_valid
//   digit_valid      a digit is held
//   digit_ready      downstream accepts the held digit this cycle
//   entry_cnt        digits transferred so far in the current code
//   code_done        one-cycle pulse after the last digit of a code transfers
//   overrun          sticky: a press was dropped while a digit was held
// Modports: master = code_entry, slave = downstream consumer.
interface code_entry_if;
    import lock_pkg::*;

    logic [DIGIT_W-1:0] digit;
    logic               digit_err;
    logic               digit_valid;
    logic               digit_ready;
    logic [CNT_W-1:0]   entry_cnt;
    logic               code_done;
    logic               overrun;

    modport master (
        output digit, digit_err, digit_valid, entry_cnt, code_done, overrun,
        input  digit_ready
    );

    modport slave (
        input  digit, digit_err, digit_valid, entry_cnt, code_done, overrun,
        output digit_ready
    );

endinterface

// File: rtl/code_entry_key_debounce.sv
// key_debounce: two-flop synchronizers for the enter key and the digit
// switches, key debounce, and press detection.
//   clk, reset  system clock, async active-high reset
//   key_n, sw   raw asynchronous inputs
//   key_level   debounced key level (1 = released)
//   press       one-cycle strobe, debounced level fell 1->0
//   sw_cap      synchronized switches captured on the falling-level cycle
// Build option: CODE_ENTRY_DEBOUNCE_EN enables the debounce counter;
// without it the synchronized key is the debounced level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SW_W            = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            key_n,
    input  logic [SW_W-1:0] sw,
    output logic            key_level,
    output logic            press,
    output logic [SW_W-1:0] sw_cap
);

    logic            key_s1, key_s2;
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic            level_d;
    logic            fall_c;

`ifdef CODE_ENTRY_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has persisted; any bounce back restarts.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = key_level;
        if (key_s2 == key_level) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = key_s2;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign level_d = key_s2;
`endif

    assign fall_c = key_level & ~level_d;

    // Synchronizers, debounced level, press strobe and switch capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            sw_s1     <= '0;
            sw_s2     <= '0;
            key_level <= 1'b1;
            press     <= 1'b0;
            sw_cap    <= '0;
        end else begin
            key_s1    <= key_n;
            key_s2    <= key_s1;
            sw_s1     <= sw;
            sw_s2     <= sw_s1;
            key_level <= level_d;
            press     <= fall_c;
            if (fall_c) sw_cap <= sw_s2;
        end
    end

endmodule

// File: rtl/code_entry.sv
// code_entry: turns debounced key presses into digits held on a
// valid/ready bus, counts digits per code and flags dropped presses.
//   clk, reset  system clock, async active-high reset
//   key_n       raw active-low enter button
//   sw          raw 4-bit digit switches
//   bus         code_entry_if.master digit hand-off (see interface)
// Build option: CODE_ENTRY_DEBOUNCE_EN (passed through to key_debounce).
module code_entry
    import lock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CODE_LEN        = lock_pkg::CODE_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_n,
    input  logic [DIGIT_W-1:0] sw,
    code_entry_if.master       bus
);

    logic               key_level;
    logic               press;
    logic [DIGIT_W-1:0] sw_cap;

    out_state_t         state_q, state_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               xfer_c;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SW_W            (DIGIT_W)
    ) u_key (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .sw        (sw),
        .key_level (key_level),
        .press     (press),
        .sw_cap    (sw_cap)
    );

    assign xfer_c = (state_q == FULL) & bus.digit_ready;

    // Output register state machine and per-code digit counter.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            EMPTY: begin
                if (press) begin
                    state_d = FULL;
                    digit_d = sw_cap;
                    err_d   = (sw_cap > DIGIT_W'(MAX_DIGIT));
                end
            end
            FULL: begin
                if (press && xfer_c) begin
                    digit_d = sw_cap;
                    err_d   = (sw_cap > DIGIT_W'(MAX_DIGIT));
                end else if (press) begin
                    ovr_d = 1'b1;
                end else if (xfer_c) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Error digits count toward the code like any other digit.
        if (xfer_c) begin
            if (cnt_q == CNT_W'(CODE_LEN - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            digit_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_err   = err_q;
    assign bus.digit_valid = (state_q == FULL);
    assign bus.entry_cnt   = cnt_q;
    assign bus.code_done   = done_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: doc/code_entry.md
CODE_ENTRY -- requirements
Module: code_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning clk cycles the raw key must hold a new level before it is accepted.
REQ-002 SHALL have parameter CODE_LEN, default 6, meaning digits per complete code.
REQ-003 SHALL have port clk  input  1  single system clock; all state is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_n  input  1  raw enter pushbutton, active-low, asynchronous to clk.
REQ-006 SHALL have port sw  input  4  raw digit switches, asynchronous to clk.
REQ-007 SHALL have port digit  output  4  captured digit value, meaningful only while digit_valid=1.
REQ-008 SHALL have port digit_err  output  1  captured digit is greater than 9; qualified by digit_valid.
REQ-009 SHALL have port digit_valid  output  1  digit and digit_err are held for the downstream lock FSM.
REQ-010 SHALL have port digit_ready  input  1  the downstream stage accepts the digit this cycle.
REQ-011 SHALL have port entry_cnt  output  3  number of digits transferred in the current code, range 0..CODE_LEN-1.
REQ-012 SHALL have port code_done  output  1  one-cycle pulse when the CODE_LEN-th digit transfers.
REQ-013 SHALL have port overrun  output  1  sticky flag; a press was dropped because the output register was occupied.

Function
REQ-014 SHALL pass key_n and sw through two-flop synchronizers before any other use.
REQ-015 SHALL update a debounced key level only after the synchronized key has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced level SHALL clear the count.
REQ-016 SHALL define a press event as the debounced level changing from 1 to 0, and SHALL capture the synchronized sw on that same cycle.
REQ-017 SHALL implement an output state machine with two states: EMPTY (digit_valid=0) and FULL (digit_valid=1).
REQ-018 SHALL, on a press in EMPTY, enter FULL on the next edge with digit set to the captured sw and digit_err set to (captured sw > 9); the latency is one cycle from the press event.
REQ-019 SHALL define a transfer as digit_valid & digit_ready on the same cycle; on a transfer without a press, it SHALL go FULL->EMPTY.
REQ-020 SHALL, when a press and a transfer occur on the same cycle, load the new digit and remain FULL.
REQ-021 SHALL, on a press in FULL without a transfer, drop the new digit, leave digit/digit_err unchanged, and set overrun until reset.
REQ-022 SHALL hold digit and digit_err stable while FULL and not transferring.
REQ-023 SHALL increment entry_cnt on each transfer; when the transfer brings the count to CODE_LEN, it SHALL set entry_cnt to 0 and assert code_done for exactly that cycle (registered, visible the following cycle).
REQ-024 SHALL count digits with digit_err=1 the same as valid digits.
REQ-025 SHALL ignore key releases (0->1) other than updating the debounced level.

Reset
REQ-026 SHALL, on reset asserted, immediately drive digit_valid=0, digit=0, digit_err=0, entry_cnt=0, code_done=0, overrun=0 and put the state machine in EMPTY.
REQ-027 SHALL, on reset, set the key synchronizer and debounced level to 1 (released), the sw synchronizer to 0, and the debounce counter to 0.
REQ-028 SHALL discard any held digit and any partial code count on a reset asserted mid-operation; no press event SHALL be generated by reset release itself.

Configuration
REQ-029 SHALL, with CODE_ENTRY_DEBOUNCE_EN defined, implement the debounce of REQ-015.
REQ-030 SHALL, without CODE_ENTRY_DEBOUNCE_EN, omit the debounce counter, use the synchronized key directly as the debounced level, and ignore DEBOUNCE_CYCLES.

Structure
REQ-031 SHALL take DIGIT_W=4, MAX_DIGIT=9, the CODE_LEN default and the EMPTY/FULL state encoding from shared package lock_pkg.
REQ-032 SHALL implement synchronizer and debounce in one sub-module, key_debounce, that outputs the debounced level and a one-cycle press strobe.

Verification (DEBOUNCE_CYCLES=4, CODE_ENTRY_DEBOUNCE_EN defined)
REQ-033 SHALL cover: sw=5, key_n low 10 cycles, digit_ready=1 -> exactly one digit_valid cycle with digit=5, digit_err=0, then entry_cnt=1.
REQ-034 SHALL cover: sw=10 (4'b1010), one press -> digit=10, digit_err=1, entry_cnt increments.
REQ-035 SHALL cover: key_n low for 2 cycles, then high -> digit_valid stays 0 and entry_cnt is unchanged.
REQ-036 SHALL cover: presses of 5,5,0,2,4,5 with digit_ready=1 -> six transfers in that order, code_done high for one cycle after the sixth, entry_cnt=0.
REQ-037 SHALL cover: digit_ready=0 with presses of 3 then 7 -> digit stays 3, overrun=1; raising digit_ready transfers 3, then digit_valid=0.
REQ-038 SHALL cover: reset pulse while digit_valid=1 and entry_cnt=4 -> digit_valid, entry_cnt and overrun read 0 before the next clk edge.
